uart_alu_intf: RTL
==================

// Module: uart_alu_intf
// PURPOSE
//  Frame consumer downstream of the uart block. Pops three bytes from the UART RX FIFO: operand A, operand B, opcode.
//  Drives them to an external combinational ALU, captures the result and pushes it into the UART TX FIFO.
//  Replaces the loop-back/debounce test top in the TP2 calculator datapath.
// PARAMETERS
//  DBIT        8     data/operand width, equal to the uart word width
//  OP_W        6     opcode width; the low OP_W bits of the opcode byte are used
//  TIMEOUT_CYC 50000000  idle clocks allowed between bytes of one frame before it is discarded (>=2)
// PORTS
//  clk         in   1       system clock
//  reset       in   1       asynchronous, active-low reset
//  rx_empty    in   1       uart RX FIFO empty
//  r_data      in   DBIT    uart RX FIFO head word (valid while rx_empty=0)
//  rd_uart     out  1       RX FIFO pop strobe
//  tx_full     in   1       uart TX FIFO full
//  wr_uart     out  1       TX FIFO push strobe
//  w_data      out  DBIT    word pushed to TX FIFO
//  alu_a       out  DBIT    registered operand A
//  alu_b       out  DBIT    registered operand B
//  alu_op      out  OP_W    registered opcode
//  alu_result  in   DBIT    combinational ALU result of alu_a/alu_b/alu_op
//  done_tick   out  1       1-cycle pulse when a result is pushed
//  frame_err   out  1       1-cycle pulse when a partial frame times out
// BEHAVIOUR
//  Reset (async, reset=0): state GET_A. alu_a, alu_b, alu_op, result reg, timer = 0. All strobes/pulses = 0.
//  Reset mid-frame drops the partial frame; FIFO contents are the uart's concern.
//  FSM states: GET_A, GET_B, GET_OP, EXEC, SEND.
//  GET_x: rd_uart = ~rx_empty (combinational, same cycle). On that edge r_data is latched into the target register, then advance.
//  Latching into alu_op uses r_data[OP_W-1:0]. No pop when rx_empty=1.
//  EXEC: exactly 1 cycle. At its closing edge alu_result is latched into the result reg; go to SEND.
//  SEND: w_data = result reg. wr_uart = ~tx_full.
//  When wr_uart=1: done_tick=1 in the same cycle, then go to GET_A. While tx_full=1, hold SEND with w_data stable; nothing is dropped.
//  Latency: opcode pop at edge k; earliest wr_uart is the cycle after edge k+1.
//  Hence max one pop per cycle during GET_x. No pops during EXEC/SEND.
//  Timeout: the timer clears on every pop and in GET_A/EXEC/SEND. It counts +1 per clock in GET_B/GET_OP while rx_empty=1.
//  When timer==TIMEOUT_CYC-1: frame_err=1 for that cycle, then next state GET_A. Registers keep old values.
//  A pop in the same cycle as expiry wins: the byte is accepted and there is no error.
//  Arithmetic is entirely inside the ALU. This block does no width extension; the result is DBIT bits, wrap is implicit.
//  wr_uart and rd_uart are never high together.
// STRUCTURE
//  Shared package/header (calc_defs): FSM state localparams.
//  It also holds the ALU opcode constants, shared with the ALU:
//    ADD 6'h20, SUB 6'h22, AND 6'h24, OR 6'h25, XOR 6'h26, NOR 6'h27, SRA 6'h03, SRL 6'h02.
//  One sub-module: frame_timer (clear/enable/expire counter, width $clog2(TIMEOUT_CYC)). FSM and registers live in the top.
// TESTING  (bench: behavioural FIFO models + reference ALU, TIMEOUT_CYC=100)
//  1. FIFO holds 0x05,0x03,0x20 -> three rd_uart pulses on consecutive cycles; one wr_uart with w_data=0x08; done_tick once.
//  2. Same frame, tx_full=1 for 10 cycles in SEND -> wr_uart=0, w_data held 0x08; tx_full drops -> exactly one push.
//  3. 0x03,0x05,0x22 (SUB) -> w_data=0xFE, 8-bit wrap. 0x81,0x01,0x03 (SRA) -> 0xC0.
//  4. Byte A, then 50-cycle gap, then B and OP -> no frame_err, result sent.
//     A, then 100-cycle gap -> frame_err pulse on cycle 99; the next byte is taken as A.
//  5. Six bytes queued -> pops for frame 1, stall in EXEC/SEND, then pops for frame 2; two ordered results.
//  6. reset=0 while in GET_OP with A,B latched -> alu_a/alu_b=0 and strobes=0 immediately.
//     After release, frame 0x01,0x01,0x20 -> 0x02.

Source files
------------

// File: rtl/calc_defs.sv
// rtl/calc_defs.sv - shared FSM states and ALU opcode constants for the calculator datapath
package calc_defs;

    typedef enum logic [2:0] {
        GET_A  = 3'd0,
        GET_B  = 3'd1,
        GET_OP = 3'd2,
        EXEC   = 3'd3,
        SEND   = 3'd4
    } state_t;

    // Opcode values are also decoded by the external ALU; keep the two in step.
    localparam logic [5:0] OP_ADD = 6'h20;
    localparam logic [5:0] OP_SUB = 6'h22;
    localparam logic [5:0] OP_AND = 6'h24;
    localparam logic [5:0] OP_OR  = 6'h25;
    localparam logic [5:0] OP_XOR = 6'h26;
    localparam logic [5:0] OP_NOR = 6'h27;
    localparam logic [5:0] OP_SRA = 6'h03;
    localparam logic [5:0] OP_SRL = 6'h02;

endpackage

// File: rtl/frame_timer.sv
// rtl/frame_timer.sv - inter-byte idle counter that flags an abandoned frame
module frame_timer #(
    parameter int TIMEOUT_CYC = 50000000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear_i,
    input  logic en_i,
    output logic expire_o
);

    localparam int W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [W-1:0] LAST = W'(TIMEOUT_CYC - 1);

    logic [W-1:0] cnt_q;

    assign expire_o = en_i && (cnt_q == LAST);

    // Restart after expiry so the count never wraps inside its width.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else if (clear_i || expire_o) begin
            cnt_q <= '0;
        end else if (en_i) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/uart_alu_intf.sv
// rtl/uart_alu_intf.sv - pops A/B/opcode frames from the uart RX FIFO, pushes ALU results to TX
module uart_alu_intf
    import calc_defs::*;
#(
    parameter int DBIT        = 8,
    parameter int OP_W        = 6,
    parameter int TIMEOUT_CYC = 50000000
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            rx_empty,
    input  logic [DBIT-1:0] r_data,
    output logic            rd_uart,
    input  logic            tx_full,
    output logic            wr_uart,
    output logic [DBIT-1:0] w_data,
    output logic [DBIT-1:0] alu_a,
    output logic [DBIT-1:0] alu_b,
    output logic [OP_W-1:0] alu_op,
    input  logic [DBIT-1:0] alu_result,
    output logic            done_tick,
    output logic            frame_err
);

    state_t          state_q;
    logic [DBIT-1:0] a_q, b_q, res_q;
    logic [OP_W-1:0] op_q;
    logic            in_get, timing, timeout;

    assign in_get  = (state_q == GET_A) || (state_q == GET_B) || (state_q == GET_OP);
    // Gated by reset so no strobe leaks out while the block is held in reset.
    assign rd_uart = reset & in_get & ~rx_empty;
    assign wr_uart = (state_q == SEND) & ~tx_full;
    assign timing  = ((state_q == GET_B) || (state_q == GET_OP)) & rx_empty;

    assign done_tick = wr_uart;
    assign frame_err = timeout;
    assign w_data    = res_q;
    assign alu_a     = a_q;
    assign alu_b     = b_q;
    assign alu_op    = op_q;

    frame_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_frame_timer (
        .clk      (clk),
        .reset    (reset),
        .clear_i  (~timing),
        .en_i     (timing),
        .expire_o (timeout)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= GET_A;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            res_q   <= '0;
        end else begin
            case (state_q)
                GET_A: if (!rx_empty) begin
                    a_q     <= r_data;
                    state_q <= GET_B;
                end
                GET_B: if (!rx_empty) begin
                    b_q     <= r_data;
                    state_q <= GET_OP;
                end else if (timeout) begin
                    state_q <= GET_A;
                end
                GET_OP: if (!rx_empty) begin
                    op_q    <= r_data[OP_W-1:0];
                    state_q <= EXEC;
                end else if (timeout) begin
                    state_q <= GET_A;
                end
                EXEC: begin
                    res_q   <= alu_result;
                    state_q <= SEND;
                end
                SEND: if (!tx_full) begin
                    state_q <= GET_A;
                end
                default: state_q <= GET_A;
            endcase
        end
    end

endmodule
